// File: rtl/uart_rx_oversample.sv
// Purpose : oversampling UART receiver (16x tick, start-bit validation, framing/break detection).
// Latency : rx pin -> rxs 2 clk; rx_valid/rx_data and status pulses register 1 clk after the stop sample tick.
// Backpres: one-entry valid/ready holding register; a new byte arriving while full is dropped and flagged on overrun.
//
// Ports:
//   clk, rst_n          system clock, asynchronous active-low reset
//   dvsr[15:0]          tick divisor, one 16x tick every dvsr+1 clocks
//   rx                  asynchronous serial input, idle high
//   rx_data/rx_valid    received byte (right-justified) and holding-register full flag
//   rx_ready            consumer accepts rx_data when rx_valid & rx_ready
//   frame_err/brk       one-cycle pulses: stop bit low with data / all-zero frame with stop low
//   overrun             one-cycle pulse: good byte dropped, holding register was full
//   busy                receiver FSM is not idle
module uart_rx_oversample #(
  parameter int DBIT_WIDTH = 8,
  parameter int SB_TICK    = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [15:0]           dvsr,
  input  logic                  rx,
  output logic [DBIT_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  input  logic                  rx_ready,
  output logic                  frame_err,
  output logic                  brk,
  output logic                  overrun,
  output logic                  busy
);

  // The per-state tick counter must reach SB_TICK-1 in STOP, which exceeds
  // 15 for 1.5 / 2 stop-bit configurations.
  localparam int SW = (SB_TICK > 16) ? $clog2(SB_TICK) : 4;
  localparam int NW = (DBIT_WIDTH > 1) ? $clog2(DBIT_WIDTH) : 1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_WAIT  = 3'd4
  } state_t;

  state_t                state, state_nxt;
  logic [SW-1:0]         s, s_nxt;
  logic [NW-1:0]         n, n_nxt;
  logic [DBIT_WIDTH-1:0] sh, sh_nxt;
  logic [15:0]           cnt;
  logic                  tick;
  logic                  rx_meta, rxs;
  logic                  deliver, fe_det, brk_det;

  // ---------------------------------------------------------------------------
  // Two-flop synchronizer; resets to the idle (high) line level so that reset
  // release never looks like a start edge.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= rx;
      rxs     <= rx_meta;
    end
  end

  // ---------------------------------------------------------------------------
  // Baud tick generator. Held at zero while idle so the first START tick lands
  // exactly dvsr+1 clocks after START entry, keeping the mid-bit sample point
  // aligned to the detected falling edge. The >= compare lets a lowered dvsr
  // take effect mid-frame instead of counting all the way round.
  // ---------------------------------------------------------------------------
  assign tick = (state != ST_IDLE) && (cnt >= dvsr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= 16'd0;
    end else if (state == ST_IDLE || tick) begin
      cnt <= 16'd0;
    end else begin
      cnt <= cnt + 16'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Receiver FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      s     <= '0;
      n     <= '0;
      sh    <= '0;
    end else begin
      state <= state_nxt;
      s     <= s_nxt;
      n     <= n_nxt;
      sh    <= sh_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Receiver FSM: next state and frame-end decisions
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    s_nxt     = s;
    n_nxt     = n;
    sh_nxt    = sh;
    deliver   = 1'b0;
    fe_det    = 1'b0;
    brk_det   = 1'b0;

    case (state)
      ST_IDLE: begin
        if (!rxs) begin
          state_nxt = ST_START;
          s_nxt     = '0;
        end
      end

      ST_START: begin
        if (tick) begin
          // Half a bit in: a line that is high again was only a glitch.
          if (s == SW'(7)) begin
            if (rxs) begin
              state_nxt = ST_IDLE;
            end else begin
              state_nxt = ST_DATA;
              s_nxt     = '0;
              n_nxt     = '0;
            end
          end else begin
            s_nxt = s + 1'b1;
          end
        end
      end

      ST_DATA: begin
        if (tick) begin
          if (s == SW'(15)) begin
            s_nxt  = '0;
            // LSB arrives first; shifting right leaves it in bit 0 at the end.
            sh_nxt = {rxs, sh[DBIT_WIDTH-1:1]};
            if (n == NW'(DBIT_WIDTH - 1)) begin
              state_nxt = ST_STOP;
            end else begin
              n_nxt = n + 1'b1;
            end
          end else begin
            s_nxt = s + 1'b1;
          end
        end
      end

      ST_STOP: begin
        if (tick) begin
          if (s == SW'(SB_TICK - 1)) begin
            s_nxt = '0;
            if (rxs) begin
              deliver   = 1'b1;
              state_nxt = ST_IDLE;
            end else if (sh == '0) begin
              brk_det   = 1'b1;
              state_nxt = ST_WAIT;
            end else begin
              fe_det    = 1'b1;
              state_nxt = ST_WAIT;
            end
          end else begin
            s_nxt = s + 1'b1;
          end
        end
      end

      ST_WAIT: begin
        // A held-low line must not be taken for a fresh start bit.
        if (rxs) begin
          state_nxt = ST_IDLE;
        end
      end

      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Holding register and status pulses. A delivery in the same cycle as a
  // consumer accept refills the register rather than dropping the byte.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      brk       <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= fe_det;
      brk       <= brk_det;
      overrun   <= deliver && rx_valid && !rx_ready;
      if (deliver && (!rx_valid || rx_ready)) begin
        rx_data  <= sh;
        rx_valid <= 1'b1;
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

  assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_oversample.sv
module tb_uart_rx_oversample;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] dvsr;
  logic        rx;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        frame_err;
  logic        brk;
  logic        overrun;
  logic        busy;

  always #5 clk = ~clk;

  uart_rx_oversample #(.DBIT_WIDTH(8), .SB_TICK(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .dvsr      (dvsr),
    .rx        (rx),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .frame_err (frame_err),
    .brk       (brk),
    .overrun   (overrun),
    .busy      (busy)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Free-running cycle count, used to time events relative to a start edge.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Observer: counts pulses and records every accepted byte.
  int         fe_cnt    = 0;
  int         brk_cnt   = 0;
  int         ovr_cnt   = 0;
  int         got_n     = 0;
  int         vrise_cyc = 0;
  logic       prev_v    = 1'b0;
  logic [7:0] got_arr [0:255];

  always @(negedge clk) begin
    if (frame_err) fe_cnt  = fe_cnt + 1;
    if (brk)       brk_cnt = brk_cnt + 1;
    if (overrun)   ovr_cnt = ovr_cnt + 1;
    if (rx_valid && !prev_v) vrise_cyc = cyc;
    prev_v = rx_valid;
    if (rx_valid && rx_ready) begin
      got_arr[got_n & 255] = rx_data;
      got_n = got_n + 1;
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int last_start = 0;

  task automatic tick(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // 8 data bits LSB first, 16*u clocks per bit; rx is left at the stop level.
  task automatic send_frame(input logic [7:0] d, input logic stop_b, input int u);
    rx = 1'b0;
    last_start = cyc;
    tick(16 * u);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      tick(16 * u);
    end
    rx = stop_b;
    tick(16 * u);
  endtask

  // Pin to START entry is 3 clocks (2 sync + 1 FSM); the stop sample falls
  // 8 + 16*8 + 16 ticks later and outputs register on that edge.
  function automatic int valid_lat(input int u);
    return 3 + (8 + 16 * 8 + 16) * u;
  endfunction

  int         g0, fe0, brk0, ovr0, st, u, gap, kind;
  logic [7:0] d;
  logic       stop_b;
  logic [7:0] exp_q[$];
  int         exp_fe, exp_brk;

  initial begin
    rst_n    = 1'b0;
    rx       = 1'b1;
    rx_ready = 1'b0;
    dvsr     = 16'd0;
    #1;
    chk("reset rx_valid",  rx_valid,  0);
    chk("reset rx_data",   rx_data,   0);
    chk("reset busy",      busy,      0);
    chk("reset frame_err", frame_err, 0);
    chk("reset brk",       brk,       0);
    chk("reset overrun",   overrun,   0);
    tick(3);
    rst_n = 1'b1;
    tick(5);

    // ---- single frame 0xA5, dvsr=0 ----
    g0 = got_n; fe0 = fe_cnt; brk0 = brk_cnt; ovr0 = ovr_cnt;
    send_frame(8'hA5, 1'b1, 1);
    chk("a5 latency",  vrise_cyc - last_start, valid_lat(1));
    chk("a5 valid",    rx_valid, 1);
    chk("a5 data",     rx_data, 8'hA5);
    chk("a5 flags",    (fe_cnt - fe0) + (brk_cnt - brk0) + (ovr_cnt - ovr0), 0);
    rx_ready = 1'b1;
    tick(1);
    chk("a5 valid drop", rx_valid, 0);
    chk("a5 accepted n", got_n - g0, 1);
    chk("a5 accepted d", got_arr[g0 & 255], 8'hA5);
    rx_ready = 1'b0;
    tick(10);

    // ---- back-to-back overrun, dvsr=3 ----
    dvsr = 16'd3;
    g0 = got_n; ovr0 = ovr_cnt; fe0 = fe_cnt;
    st = cyc;
    send_frame(8'h3C, 1'b1, 4);
    send_frame(8'h99, 1'b1, 4);
    send_frame(8'h7E, 1'b1, 4);
    chk("ovr latency", vrise_cyc - st, valid_lat(4));
    chk("ovr count",   ovr_cnt - ovr0, 2);
    chk("ovr valid",   rx_valid, 1);
    chk("ovr data",    rx_data, 8'h3C);
    chk("ovr fe",      fe_cnt - fe0, 0);
    rx_ready = 1'b1;
    tick(1);
    rx_ready = 1'b0;
    chk("ovr drain d", got_arr[g0 & 255], 8'h3C);
    chk("ovr drain v", rx_valid, 0);
    tick(10);

    // ---- start glitch, dvsr=0 ----
    dvsr = 16'd0;
    fe0 = fe_cnt; brk0 = brk_cnt; st = vrise_cyc;
    rx = 1'b0;
    tick(4);
    rx = 1'b1;
    chk("glitch busy up",   busy, 1);
    tick(6);
    chk("glitch busy mid",  busy, 1);
    tick(10);
    chk("glitch busy down", busy, 0);
    chk("glitch no valid",  vrise_cyc - st, 0);
    chk("glitch flags",     (fe_cnt - fe0) + (brk_cnt - brk0), 0);

    // ---- framing error 0x55 ----
    rx_ready = 1'b1;
    g0 = got_n; fe0 = fe_cnt; brk0 = brk_cnt;
    send_frame(8'h55, 1'b0, 1);
    tick(40);
    chk("fe wait busy", busy, 1);
    chk("fe pulse",     fe_cnt - fe0, 1);
    chk("fe no brk",    brk_cnt - brk0, 0);
    chk("fe no data",   got_n - g0, 0);
    rx = 1'b1;
    tick(4);
    chk("fe idle",      busy, 0);
    chk("fe single",    fe_cnt - fe0, 1);

    // ---- break: 3 frame times low ----
    g0 = got_n; fe0 = fe_cnt; brk0 = brk_cnt;
    rx = 1'b0;
    tick(480);
    chk("brk wait busy", busy, 1);
    rx = 1'b1;
    tick(20);
    chk("brk pulse",   brk_cnt - brk0, 1);
    chk("brk no fe",   fe_cnt - fe0, 0);
    chk("brk no data", got_n - g0, 0);
    chk("brk idle",    busy, 0);
    rx_ready = 1'b0;
    send_frame(8'h81, 1'b1, 1);
    tick(2);
    chk("post-brk valid", rx_valid, 1);
    chk("post-brk data",  rx_data, 8'h81);

    // ---- reset mid-DATA while holding 0x81 ----
    rx = 1'b0;
    tick(16);
    rx = 1'b1;
    tick(40);
    chk("rst pre busy", busy, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst valid", rx_valid, 0);
    chk("rst data",  rx_data, 0);
    chk("rst busy",  busy, 0);
    tick(3);
    rst_n = 1'b1;
    tick(200);
    rx_ready = 1'b1;
    g0 = got_n; fe0 = fe_cnt; brk0 = brk_cnt;
    send_frame(8'hC3, 1'b1, 1);
    tick(4);
    chk("rst c3 n",     got_n - g0, 1);
    chk("rst c3 d",     got_arr[g0 & 255], 8'hC3);
    chk("rst c3 flags", (fe_cnt - fe0) + (brk_cnt - brk0), 0);

    // ---- randomized frames against a frame-level reference ----
    g0 = got_n; fe0 = fe_cnt; brk0 = brk_cnt; ovr0 = ovr_cnt;
    exp_fe = 0; exp_brk = 0;
    for (int i = 0; i < 16; i++) begin
      u    = int'($urandom_range(1, 4));
      dvsr = 16'(u - 1);
      d    = 8'($urandom);
      kind = int'($urandom_range(0, 5));
      stop_b = (kind > 1);
      if (kind == 0) d = 8'h00;
      if (kind == 1 && d == 8'h00) d = 8'h01;
      if (stop_b)           exp_q.push_back(d);
      else if (d == 8'h00)  exp_brk++;
      else                  exp_fe++;
      send_frame(d, stop_b, u);
      if (!stop_b) begin
        tick(32 * u);
        rx = 1'b1;
      end
      gap = int'($urandom_range(2, 20));
      tick(gap);
    end
    tick(4);
    chk("rand count", got_n - g0, exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      chk($sformatf("rand byte %0d", i), got_arr[(g0 + i) & 255], exp_q[i]);
    end
    chk("rand fe",  fe_cnt - fe0,   exp_fe);
    chk("rand brk", brk_cnt - brk0, exp_brk);
    chk("rand ovr", ovr_cnt - ovr0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
